// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared FSM state type and line constants for the USB receive deserializer.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STUFF
  } state_e;

  localparam logic IDLE_LINE       = 1'b1;
  localparam int   DEF_STUFF_LIMIT = 6;

endpackage

// File: rtl/flex_stp_sr.sv
// flex_stp_sr: parameterized serial-to-parallel shift register with synchronous clear.
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  logic [NUM_BITS-1:0] word_q;

  // SHIFT_MSB=0 enters new bits at the MSB, so the first bit received ends at bit 0
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_q <= '0;
    end else if (clear) begin
      word_q <= '0;
    end else if (shift_enable) begin
      word_q <= SHIFT_MSB ? {word_q[NUM_BITS-2:0], serial_in}
                          : {serial_in, word_q[NUM_BITS-1:1]};
    end
  end

  assign parallel_out = word_q;

endmodule

// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer: NRZI decode, bit-stuff removal and LSB-first byte assembly of USB RX line bits.
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int NUM_BITS    = 8,
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                rx_active,
  input  logic                bit_strobe,
  input  logic                line_bit,
  input  logic                eop,
  output logic [NUM_BITS-1:0] rx_byte,
  output logic                byte_valid,
  output logic                stuff_err,
  output logic                align_err
);

  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);

  state_e              state_q;
  logic                prev_line_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [OW-1:0]       ones_cnt_q;
  logic [NUM_BITS-1:0] rx_byte_q;
  logic                byte_valid_q;
  logic                stuff_err_q;
  logic                align_err_q;

  logic                dec;
  logic [OW-1:0]       ones_inc;
  logic                last_bit;
  logic                eop_hit;
  logic                clear_sr;
  logic                shift_en;
  logic [NUM_BITS-1:0] sr_word;

  always_comb begin
    dec      = (line_bit == prev_line_q);
    ones_inc = dec ? ones_cnt_q + 1'b1 : '0;
    last_bit = (bit_cnt_q == BW'(NUM_BITS - 1));
    eop_hit  = rx_active && (state_q != IDLE) && eop;
    clear_sr = !rx_active || (state_q == IDLE) || eop_hit;
    shift_en = rx_active && (state_q == DATA) && bit_strobe && !eop;
  end

  flex_stp_sr #(
    .NUM_BITS (NUM_BITS),
    .SHIFT_MSB(1'b0)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear_sr),
    .shift_enable(shift_en),
    .serial_in   (dec),
    .parallel_out(sr_word)
  );

  // eop beats a coincident strobe; a stuffed bit updates prev_line but is never shifted or counted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      prev_line_q  <= IDLE_LINE;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
      if (!rx_active) begin
        state_q     <= IDLE;
        prev_line_q <= IDLE_LINE;
        bit_cnt_q   <= '0;
        ones_cnt_q  <= '0;
      end else if (state_q == IDLE) begin
        state_q <= DATA;
      end else if (eop) begin
        align_err_q <= (bit_cnt_q != '0);
        state_q     <= DATA;
        prev_line_q <= IDLE_LINE;
        bit_cnt_q   <= '0;
        ones_cnt_q  <= '0;
      end else if (bit_strobe) begin
        prev_line_q <= line_bit;
        if (state_q == STUFF) begin
          stuff_err_q <= dec;
          ones_cnt_q  <= '0;
          state_q     <= DATA;
        end else begin
          ones_cnt_q <= ones_inc;
          bit_cnt_q  <= last_bit ? '0 : bit_cnt_q + 1'b1;
          if (last_bit) begin
            rx_byte_q    <= NUM_BITS'({dec, sr_word} >> 1);
            byte_valid_q <= 1'b1;
          end
          if (ones_inc == OW'(STUFF_LIMIT)) state_q <= STUFF;
        end
      end
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign stuff_err  = stuff_err_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// tb_usb_rx_deserializer: directed line-bit vectors with a scoreboard of expected output pulses.
module tb_usb_rx_deserializer;

  localparam logic [15:0] A5_LINE    = 16'h00C9;
  localparam logic [15:0] STUFF_LINE = 16'h003F;
  localparam logic [15:0] ZERO_LINE  = 16'h00AA;
  localparam logic [15:0] ONES_LINE  = 16'h007F;

  localparam int K_BYTE  = 0;
  localparam int K_STUFF = 1;
  localparam int K_ALIGN = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx_active = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       line_bit = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       stuff_err;
  logic       align_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  usb_rx_deserializer dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_active (rx_active),
    .bit_strobe(bit_strobe),
    .line_bit  (line_bit),
    .eop       (eop),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .stuff_err (stuff_err),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d rx_byte=%0h required=none", kind, rx_byte);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind == K_BYTE && rx_byte !== e.data)) begin
        failures++;
        $display("FAIL event actual_kind=%0d rx_byte=%0h required_kind=%0d data=%0h",
                 kind, rx_byte, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (byte_valid) observe(K_BYTE);
      if (stuff_err)  observe(K_STUFF);
      if (align_err)  observe(K_ALIGN);
    end
  end

  task automatic strobe(input logic b, input logic e);
    @(posedge clk);
    #1;
    bit_strobe = 1'b1;
    line_bit   = b;
    eop        = e;
    @(posedge clk);
    #1;
    bit_strobe = 1'b0;
    eop        = 1'b0;
  endtask

  task automatic pulse_eop();
    @(posedge clk);
    #1;
    eop = 1'b1;
    @(posedge clk);
    #1;
    eop = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) strobe(v[i], 1'b0);
  endtask

  initial begin
    #2;
    check("reset_rx_byte", 32'(rx_byte), 0);
    check("reset_byte_valid", 32'(byte_valid), 0);
    check("reset_stuff_err", 32'(stuff_err), 0);
    check("reset_align_err", 32'(align_err), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    rx_active = 1'b1;
    repeat (2) @(posedge clk);
    expect_ev(K_BYTE, 8'hA5);
    send(A5_LINE, 8);
    pulse_eop();
    expect_ev(K_BYTE, 8'hFF);
    send(STUFF_LINE, 9);
    pulse_eop();
    expect_ev(K_STUFF, 8'h00);
    send(ONES_LINE, 7);
    expect_ev(K_BYTE, 8'hFF);
    send(16'h0003, 2);
    expect_ev(K_BYTE, 8'hA5);
    send(A5_LINE, 8);
    send(A5_LINE, 3);
    expect_ev(K_ALIGN, 8'h00);
    pulse_eop();
    expect_ev(K_BYTE, 8'hA5);
    send(A5_LINE, 8);
    send(A5_LINE, 7);
    expect_ev(K_ALIGN, 8'h00);
    strobe(1'b1, 1'b1);
    expect_ev(K_BYTE, 8'hA5);
    send(A5_LINE, 8);
    send(A5_LINE, 4);
    @(posedge clk);
    #1;
    rx_active = 1'b0;
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    @(posedge clk);
    #1;
    rx_active = 1'b1;
    repeat (2) @(posedge clk);
    expect_ev(K_BYTE, 8'hA5);
    send(A5_LINE, 8);
    send(A5_LINE, 4);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("async_rst_rx_byte", 32'(rx_byte), 0);
    check("async_rst_byte_valid", 32'(byte_valid), 0);
    check("async_rst_stuff_err", 32'(stuff_err), 0);
    check("async_rst_align_err", 32'(align_err), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    expect_ev(K_BYTE, 8'h00);
    send(ZERO_LINE, 8);
    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_deserializer.md
# usb_rx_deserializer

Receive-side counterpart of the USB transmit parallel-to-serial path. Takes sampled line bits qualified by a one-cycle bit strobe and performs four steps:
- NRZI-decodes each bit.
- Removes stuffed bits.
- Assembles LSB-first bits into bytes.
- Emits each completed byte with a one-cycle valid pulse.

Sits between the RX bit-timing/edge-sync logic and the RX packet-decode FSM.

## Interface
Parameters:
- NUM_BITS, 8, width of an assembled word.
- STUFF_LIMIT, 6, consecutive decoded ones after which a stuffed zero is expected.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- rx_active  input  1  high while a packet is being received; low forces idle.
- bit_strobe  input  1  one-cycle pulse, line_bit valid this cycle.
- line_bit  input  1  synchronized D+ level sampled at bit centre.
- eop  input  1  one-cycle pulse, end-of-packet detected.
- rx_byte  output  NUM_BITS  last completed byte, held until next completion.
- byte_valid  output  1  one-cycle pulse, rx_byte updated.
- stuff_err  output  1  one-cycle pulse, bit-stuff violation.
- align_err  output  1  one-cycle pulse, eop with a partial byte pending.

## Operation
**NRZI decode**
- Decoded bit = 1 when line_bit equals prev_line, else 0.
- prev_line updates on every accepted strobe, including stuffed bits.
- prev_line resets to 1 (idle J).

**FSM states**
- IDLE: entered on reset or when rx_active=0.
  - Clears bit_cnt, ones_cnt and the shift register.
  - Sets prev_line=1.
  - Ignores strobes.
  - Moves to DATA when rx_active=1.
- DATA: on bit_strobe, decode the bit.
  - Decoded 1: ones_cnt++.
  - Decoded 0: ones_cnt=0.
  - The bit shifts into the MSB and the register shifts right, so the first-received bit ends at bit 0.
  - bit_cnt++.
  - When bit_cnt wraps from NUM_BITS-1 to 0: the register is copied to rx_byte and byte_valid pulses.
  - If ones_cnt reaches STUFF_LIMIT after this bit, go to STUFF.
- STUFF: the next strobed bit is not shifted and bit_cnt is unchanged.
  - Decoded 0: ones_cnt=0, return to DATA.
  - Decoded 1: stuff_err pulses, ones_cnt=0, bit discarded, return to DATA.
  - Stuff removal applies across byte boundaries, so a stuffed bit may follow a byte completion.

**eop**, in any non-IDLE state:
- If bit_cnt≠0, align_err pulses.
- Partial data is dropped; bit_cnt, ones_cnt and state reset to DATA, prev_line=1.
- rx_byte is retained.

**Boundary conditions**
- eop and bit_strobe in the same cycle: eop wins and the strobed bit is discarded.
- rx_active falling mid-byte: go to IDLE silently, no align_err.
- bit_strobe while rx_active=0: ignored.
- Asynchronous reset mid-byte: all state and outputs return to reset values immediately.

## Timing
- Reset values: rx_byte=0, byte_valid=0, stuff_err=0, align_err=0, state IDLE, prev_line=1.
- byte_valid, stuff_err and align_err are registered and assert in the cycle after the triggering strobe or eop, for exactly one cycle.
- rx_byte changes in the same cycle byte_valid asserts.
- Strobes are at least 2 cycles apart; consecutive-cycle strobes are unsupported.

## Structure
- Package usb_rx_pkg holds:
  - state enum (IDLE, DATA, STUFF);
  - IDLE_LINE = 1'b1;
  - default STUFF_LIMIT.
- Sub-module flex_stp_sr: parameterized serial-to-parallel shift register (NUM_BITS, SHIFT_MSB), instantiated with NUM_BITS=8, SHIFT_MSB=0.
  - shift_enable = accepted non-stuff strobe.
  - Cleared by n_rst and by an idle/eop clear.
- The FSM, NRZI register, counters and output registers live in the top module.

## Test plan
- Byte decode: line bits 1,0,0,1,0,0,1,1 → one byte_valid pulse with rx_byte=0xA5; no errors.
- Stuffed zero removed: line bits 1,1,1,1,1,1,0,0,0 (9 strobes) → single byte_valid with rx_byte=0xFF; stuffed bit not counted.
- Stuff violation: seven consecutive line bits at 1 → stuff_err pulses one cycle after the 7th strobe; the next valid byte still decodes correctly.
- Partial byte at eop: three strobes then eop → align_err pulse, no byte_valid. A following 0xA5 sequence yields rx_byte=0xA5.
- Simultaneous eop and strobe:
  - eop together with the 8th strobe → align_err, no byte_valid.
  - eop with bit_cnt=0 → no align_err.
- Reset and rx_active:
  - n_rst asserted after 4 bits → all outputs 0 immediately; next full byte decodes correctly.
  - rx_active low mid-byte → no pulses.
